// File: rtl/truth_table_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_checker_pkg
//  Description : Shared definitions for the truth-table checker: sweep state
//                encoding, reference truth tables for common 2-input gates,
//                and the settle-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package truth_table_checker_pkg;

    // Sweep state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    // Reference truth tables; bit i is the gate output for input combination i
    localparam logic [3:0] c_tt_or  = 4'b1110;
    localparam logic [3:0] c_tt_and = 4'b1000;
    localparam logic [3:0] c_tt_xor = 4'b0110;

    // Width of the settle down-counter (SETTLE range 0..15)
    localparam int c_settle_w = 4;

endpackage : truth_table_checker_pkg
`default_nettype wire

// File: rtl/truth_table_checker_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : settle_timer
//  Description : Loadable down-counter with a zero flag. Load has priority
//                over decrement; decrementing stops at zero.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_load        - load i_load_val into the counter
//                i_load_val    - reload value
//                i_dec         - decrement by one (saturates at zero)
//                o_zero        - counter is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_checker
//  Description : Sweeps every input combination of a small combinational gate
//                in ascending order, samples the gate output after a settle
//                delay and compares it with an expected truth table. Reports
//                pass/fail, the mismatch count and the first failing index.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                start           - begin a sweep (sampled in IDLE only)
//                dut_in          - stimulus to the gate ({a,b} for 2 inputs)
//                dut_out         - response from the gate
//                busy            - sweep in progress
//                done            - one-cycle pulse at sweep completion
//                pass            - last completed sweep had no mismatches
//                err_count       - mismatches in current/last sweep
//                first_fail      - lowest mismatching combination
//                first_fail_vld  - first_fail is valid
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                  N_IN   = 2,
    parameter logic [2**N_IN-1:0]  EXPECT = c_tt_or,
    parameter int                  SETTLE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld
);

    localparam logic [c_settle_w-1:0] c_settle_val = c_settle_w'(SETTLE);

    state_t            r_state;
    state_t            w_state_next;
    logic [N_IN-1:0]   r_index;
    logic [N_IN:0]     r_err;
    logic [N_IN:0]     w_err_next;
    logic [N_IN-1:0]   r_first_fail;
    logic              r_first_fail_vld;
    logic              r_pass;
    logic              w_timer_load;
    logic              w_timer_dec;
    logic              w_timer_zero;
    logic              w_last;
    logic              w_mismatch;

    settle_timer #(
        .WIDTH (c_settle_w)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_timer_load),
        .i_load_val (c_settle_val),
        .i_dec      (w_timer_dec),
        .o_zero     (w_timer_zero)
    );

    assign w_last = &r_index;

    // Case inequality so an unknown gate output is reported as a mismatch in
    // simulation; synthesis treats it as an ordinary inequality.
    assign w_mismatch = (dut_out !== EXPECT[r_index]);

    // Count including the current sample, so pass reflects the final mismatch
    assign w_err_next = w_mismatch ? (r_err + 1'b1) : r_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = WAIT;
                    w_timer_load = 1'b1;
                end
            end
            WAIT: begin
                busy        = 1'b1;
                w_timer_dec = 1'b1;
                if (w_timer_zero) begin
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = FIN;
                end else begin
                    w_state_next = WAIT;
                    w_timer_load = 1'b1;
                end
            end
            FIN: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sweep datapath: index, error count, first failure, pass flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index          <= '0;
            r_err            <= '0;
            r_first_fail     <= '0;
            r_first_fail_vld <= 1'b0;
            r_pass           <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_index          <= '0;
                        r_err            <= '0;
                        r_first_fail     <= '0;
                        r_first_fail_vld <= 1'b0;
                        r_pass           <= 1'b0;
                    end
                end
                SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_first_fail_vld) begin
                        r_first_fail     <= r_index;
                        r_first_fail_vld <= 1'b1;
                    end
                    // pass is registered here so it is valid during FIN
                    if (w_last) begin
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_index <= r_index + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The stimulus is the index itself, so it holds its last value after a sweep
    assign dut_in         = r_index;
    assign err_count      = r_err;
    assign first_fail     = r_first_fail;
    assign first_fail_vld = r_first_fail_vld;
    assign pass           = r_pass;

endmodule : truth_table_checker
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_checker
//  Description : Directed self-checking bench. Three checker instances share
//                clk/rst: A (OR table, SETTLE=0, gate model selectable),
//                B (AND table, SETTLE=0, AND gate), C (OR table, SETTLE=2,
//                OR gate). Expected sweep results come from a small gate
//                model and are queued at start, then compared at done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

    typedef struct {
        logic [2:0] err;
        logic [1:0] ff;
        logic       ffv;
        logic       pass;
    } exp_t;

    localparam int c_gate_or   = 0;
    localparam int c_gate_zero = 1;
    localparam int c_gate_and  = 2;

    logic       clk;
    logic       rst;
    logic       start_s          [3];
    logic [1:0] dut_in_s         [3];
    logic       dut_out_s        [3];
    logic       busy_s           [3];
    logic       done_s           [3];
    logic       pass_s           [3];
    logic [2:0] err_s            [3];
    logic [1:0] ff_s             [3];
    logic       ffv_s            [3];
    int         mode_s           [3];
    logic [3:0] tt_s             [3];
    int         settle_s         [3];

    exp_t       sb[$];
    int         n_assert;
    int         n_fail;

    function automatic logic gate(input int mode, input logic [1:0] v);
        case (mode)
            c_gate_or:  return v[1] | v[0];
            c_gate_and: return v[1] & v[0];
            default:    return 1'b0;
        endcase
    endfunction

    assign dut_out_s[0] = gate(mode_s[0], dut_in_s[0]);
    assign dut_out_s[1] = gate(mode_s[1], dut_in_s[1]);
    assign dut_out_s[2] = gate(mode_s[2], dut_in_s[2]);

    truth_table_checker #(.N_IN(2), .EXPECT(4'b1110), .SETTLE(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .dut_in(dut_in_s[0]),
        .dut_out(dut_out_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .err_count(err_s[0]), .first_fail(ff_s[0]),
        .first_fail_vld(ffv_s[0]));

    truth_table_checker #(.N_IN(2), .EXPECT(4'b1000), .SETTLE(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .dut_in(dut_in_s[1]),
        .dut_out(dut_out_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .err_count(err_s[1]), .first_fail(ff_s[1]),
        .first_fail_vld(ffv_s[1]));

    truth_table_checker #(.N_IN(2), .EXPECT(4'b1110), .SETTLE(2)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_s[2]), .dut_in(dut_in_s[2]),
        .dut_out(dut_out_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .pass(pass_s[2]), .err_count(err_s[2]), .first_fail(ff_s[2]),
        .first_fail_vld(ffv_s[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected sweep result for instance sel, from its table and gate model
    function automatic exp_t model(input int sel);
        exp_t e;
        logic [1:0] v;
        e.err = '0; e.ff = '0; e.ffv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            if (gate(mode_s[sel], v) != tt_s[sel][i]) begin
                e.err = e.err + 3'd1;
                if (!e.ffv) begin
                    e.ff  = v;
                    e.ffv = 1'b1;
                end
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    task automatic check_result(input int sel, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_err"},  32'(err_s[sel]),  32'(e.err));
            check({tag, "_ff"},   32'(ff_s[sel]),   32'(e.ff));
            check({tag, "_ffv"},  32'(ffv_s[sel]),  32'(e.ffv));
            check({tag, "_pass"}, 32'(pass_s[sel]), 32'(e.pass));
        end
    endtask

    // One sweep: start pulse, then per-cycle stimulus/busy/done checks and a
    // result check on the done cycle. pulse_at re-asserts start mid-sweep;
    // keep leaves start high for back-to-back operation.
    task automatic run_sweep(input int sel, input string tag, input int pulse_at, input bit keep);
        int per;
        int total;
        per   = settle_s[sel] + 2;
        total = 4 * per;
        sb.push_back(model(sel));
        @(negedge clk);
        start_s[sel] = 1'b1;
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            start_s[sel] = keep || (k == pulse_at);
            if (k < total) begin
                check({tag, "_dut_in"}, 32'(dut_in_s[sel]), 32'(k / per));
                check({tag, "_busy"},   32'(busy_s[sel]),   32'd1);
                check({tag, "_done"},   32'(done_s[sel]),   32'd0);
            end else begin
                check({tag, "_done_at_end"}, 32'(done_s[sel]),   32'd1);
                check({tag, "_busy_at_end"}, 32'(busy_s[sel]),   32'd0);
                check({tag, "_dut_in_end"},  32'(dut_in_s[sel]), 32'd3);
                check_result(sel, tag);
            end
        end
    endtask

    initial begin
        bit seen;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
        mode_s   = '{c_gate_or, c_gate_and, c_gate_or};
        tt_s     = '{4'b1110, 4'b1000, 4'b1110};
        settle_s = '{0, 0, 2};

        // Reset state
        #1;
        check("rst_dut_in", 32'(dut_in_s[0]), 32'd0);
        check("rst_busy",   32'(busy_s[0]),   32'd0);
        check("rst_done",   32'(done_s[0]),   32'd0);
        check("rst_pass",   32'(pass_s[0]),   32'd0);
        check("rst_err",    32'(err_s[0]),    32'd0);
        check("rst_ffv",    32'(ffv_s[0]),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // OR gate against OR table
        run_sweep(0, "or_pass", -1, 1'b0);
        @(negedge clk);
        check("or_done_one_cycle", 32'(done_s[0]), 32'd0);
        check("or_pass_held",      32'(pass_s[0]), 32'd1);

        // Output stuck at 0
        mode_s[0] = c_gate_zero;
        run_sweep(0, "zero", -1, 1'b0);

        // AND gate against OR table, then against AND table
        mode_s[0] = c_gate_and;
        run_sweep(0, "and_vs_or", -1, 1'b0);
        run_sweep(1, "and_vs_and", -1, 1'b0);

        // Longer settle time
        run_sweep(2, "settle2", -1, 1'b0);

        // start re-pulsed mid-sweep is ignored
        mode_s[0] = c_gate_or;
        run_sweep(0, "restart_ignored", 3, 1'b0);
        @(negedge clk);
        check("restart_no_rerun", 32'(busy_s[0]), 32'd0);

        // start held: back-to-back sweeps (first gives a failing result)
        mode_s[0] = c_gate_zero;
        run_sweep(0, "held1", -1, 1'b1);
        @(negedge clk);
        check("held_idle_busy", 32'(busy_s[0]), 32'd0);
        check("held_idle_pass", 32'(pass_s[0]), 32'd0);
        mode_s[0] = c_gate_or;
        sb.push_back(model(0));
        @(negedge clk);
        start_s[0] = 1'b0;
        check("held_restart_busy", 32'(busy_s[0]), 32'd1);
        check("held_restart_err",  32'(err_s[0]),  32'd0);
        check("held_restart_ffv",  32'(ffv_s[0]),  32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = done_s[0];
        end
        check("held2_done_seen", 32'(seen), 32'd1);
        if (seen) check_result(0, "held2");
        else void'(sb.pop_front());

        // Asynchronous reset mid-sweep while dut_in = 2'b10
        mode_s[0] = c_gate_or;
        sb.push_back(model(0));
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (dut_in_s[0] == 2'b10) seen = 1'b1;
            else @(negedge clk);
        end
        check("rst_mid_reached_10", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_dut_in", 32'(dut_in_s[0]), 32'd0);
        check("rst_mid_busy",   32'(busy_s[0]),   32'd0);
        check("rst_mid_pass",   32'(pass_s[0]),   32'd0);
        check("rst_mid_err",    32'(err_s[0]),    32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_s[0] || busy_s[0]) seen = 1'b1;
        end
        check("rst_mid_no_done", 32'(seen), 32'd0);
        run_sweep(0, "after_rst", -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_truth_table_checker
`default_nettype wire
